// File: rtl/mode_detect_pkg.sv
// Shared widths, timeout limits and FSM state encoding for the video mode detector.
package mode_detect_pkg;

  localparam int H_W       = 12;
  localparam int V_W       = 11;
  localparam int VSW_W     = 4;
  localparam int H_TIMEOUT = 4095;
  localparam int V_TIMEOUT = 2047;

  typedef enum logic [1:0] {
    ST_NOSYNC  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [H_W-1:0] h_absdiff(input logic [H_W-1:0] a, input logic [H_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/mode_detect_if.sv
// Status bundle of the mode detector: measured timing plus lock/sync flags.
interface mode_detect_if;
  import mode_detect_pkg::*;

  logic [H_W-1:0]   htotal;
  logic [H_W-1:0]   hsync_w;
  logic [V_W-1:0]   vtotal;
  logic [VSW_W-1:0] vsync_w;
  logic             mode_valid;
  logic             mode_changed;
  logic             sync_lost;

  modport master (output htotal, hsync_w, vtotal, vsync_w, mode_valid, mode_changed, sync_lost);
  modport slave  (input  htotal, hsync_w, vtotal, vsync_w, mode_valid, mode_changed, sync_lost);

endinterface

// File: rtl/mode_detect_sync.sv
// Edge detector plus saturating period/low-width counters for one active-low sync.
// CYCLE_MODE counts clocks (hsync); otherwise it counts tick pulses (lines for vsync).
module sync_meas #(
  parameter int               CNT_W      = 12,
  parameter int               WID_W      = 12,
  parameter logic [CNT_W-1:0] CNT_MAX    = '1,
  parameter bit               CYCLE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  input  logic             tick,
  input  logic             disarm,
  output logic             fall,
  output logic             at_max,
  output logic [CNT_W-1:0] period,
  output logic [WID_W-1:0] width
);

  logic             sync_r_q, sync_p_q;
  logic             armed_q, armed_d;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic [WID_W-1:0] wcnt_q, wcnt_d, wsum;
  logic [WID_W-1:0] width_q, width_d;

  assign fall   = sync_p_q & ~sync_r_q;
  assign rise   = ~sync_p_q & sync_r_q;
  assign at_max = (cnt_q == CNT_MAX);
  assign period = period_q;
  assign width  = width_q;

  always_comb begin
    cnt_inc  = at_max ? cnt_q : cnt_q + CNT_W'(tick);
    wsum     = (&wcnt_q) ? wcnt_q : wcnt_q + WID_W'(tick);
    cnt_d    = cnt_inc;
    period_d = period_q;
    wcnt_d   = wcnt_q;
    width_d  = width_q;
    armed_d  = armed_q;
    if (fall) begin
      cnt_d   = CYCLE_MODE ? CNT_W'(1) : '0;
      wcnt_d  = WID_W'(tick);
      armed_d = 1'b1;
      // A period is only trusted when a previous edge started it cleanly.
      if (armed_q && !disarm) begin
        period_d = CYCLE_MODE ? cnt_q : cnt_inc;
      end
    end else begin
      if (disarm) begin
        armed_d = 1'b0;
      end
      if (!sync_r_q) begin
        wcnt_d = wsum;
      end
    end
    if (rise && armed_q) begin
      width_d = wcnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r_q <= 1'b0;
      sync_p_q <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      wcnt_q   <= '0;
      width_q  <= '0;
    end else begin
      sync_r_q <= sync_in;
      sync_p_q <= sync_r_q;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wcnt_q   <= wcnt_d;
      width_q  <= width_d;
    end
  end

endmodule

// File: rtl/mode_detect.sv
// Video mode detector: measures H/V timing and locks once it is stable for STABLE_FRAMES frames.
module mode_detect
  import mode_detect_pkg::*;
#(
  parameter int STABLE_FRAMES = 3,
  parameter int H_TOL         = 2
) (
  input  logic             PCLK,
  input  logic             reset_n,
  input  logic             HSYNC_in,
  input  logic             VSYNC_in,
  output logic [H_W-1:0]   htotal,
  output logic [H_W-1:0]   hsync_w,
  output logic [V_W-1:0]   vtotal,
  output logic [VSW_W-1:0] vsync_w,
  output logic             mode_valid,
  output logic             mode_changed,
  output logic             sync_lost
);

  localparam int            SW       = $clog2(STABLE_FRAMES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_FRAMES);

  logic h_fall, h_at_max, v_fall, v_at_max, timeout, match;
  state_t         state_q, state_d;
  logic [SW-1:0]  stab_q, stab_d;
  logic           vseen_q, vseen_d;
  logic           v_evt_q, v_evt_d;
  logic [H_W-1:0] ht_ref_q, ht_ref_d;
  logic [V_W-1:0] vt_ref_q, vt_ref_d;
  logic           mode_valid_q, mode_valid_d;
  logic           mv_prev_q;
  logic           mode_changed_q, mode_changed_d;

  sync_meas #(.CNT_W(H_W), .WID_W(H_W), .CNT_MAX(H_W'(H_TIMEOUT)), .CYCLE_MODE(1'b1)) u_hmeas (
    .clk(PCLK), .rst_n(reset_n), .sync_in(HSYNC_in), .tick(1'b1), .disarm(timeout),
    .fall(h_fall), .at_max(h_at_max), .period(htotal), .width(hsync_w)
  );

  sync_meas #(.CNT_W(V_W), .WID_W(VSW_W), .CNT_MAX(V_W'(V_TIMEOUT)), .CYCLE_MODE(1'b0)) u_vmeas (
    .clk(PCLK), .rst_n(reset_n), .sync_in(VSYNC_in), .tick(h_fall), .disarm(timeout),
    .fall(v_fall), .at_max(v_at_max), .period(vtotal), .width(vsync_w)
  );

  assign timeout = h_at_max | v_at_max;
  // Evaluate the frame one cycle after the V edge, once htotal/vtotal have loaded.
  assign v_evt_d = v_fall & ~timeout;
  assign match   = (vtotal == vt_ref_q) && (h_absdiff(htotal, ht_ref_q) <= H_W'(H_TOL));

  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    vseen_d  = vseen_q;
    ht_ref_d = ht_ref_q;
    vt_ref_d = vt_ref_q;
    if (timeout) begin
      state_d = ST_NOSYNC;
      stab_d  = '0;
      vseen_d = 1'b0;
    end else if (v_evt_q) begin
      ht_ref_d = htotal;
      vt_ref_d = vtotal;
      case (state_q)
        ST_NOSYNC: begin
          if (vseen_q) begin
            state_d = ST_MEASURE;
            stab_d  = '0;
            vseen_d = 1'b0;
          end else begin
            vseen_d = 1'b1;
          end
        end
        default: begin
          if (match) begin
            stab_d = (stab_q < STAB_MAX) ? stab_q + SW'(1) : stab_q;
            if (stab_d == STAB_MAX) begin
              state_d = ST_LOCKED;
            end
          end else begin
            stab_d  = '0;
            state_d = ST_MEASURE;
          end
        end
      endcase
    end
    mode_valid_d   = (state_d == ST_LOCKED);
    mode_changed_d = mode_valid_q ^ mv_prev_q;
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_NOSYNC;
      stab_q         <= '0;
      vseen_q        <= 1'b0;
      v_evt_q        <= 1'b0;
      ht_ref_q       <= '0;
      vt_ref_q       <= '0;
      mode_valid_q   <= 1'b0;
      mv_prev_q      <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      stab_q         <= stab_d;
      vseen_q        <= vseen_d;
      v_evt_q        <= v_evt_d;
      ht_ref_q       <= ht_ref_d;
      vt_ref_q       <= vt_ref_d;
      mode_valid_q   <= mode_valid_d;
      mv_prev_q      <= mode_valid_q;
      mode_changed_q <= mode_changed_d;
    end
  end

  assign mode_valid   = mode_valid_q;
  assign mode_changed = mode_changed_q;
  assign sync_lost    = (state_q == ST_NOSYNC);

endmodule

// File: tb/tb_mode_detect.sv
// Directed bench for mode_detect: table of frame-geometry vectors plus reset, saturation and timeout sequences.
module tb_mode_detect;

  logic PCLK = 1'b0;
  logic reset_n;
  logic HSYNC_in;
  logic VSYNC_in;
  int   checks = 0;
  int   errors = 0;
  int   mc_pulses = 0;
  logic mv1 = 1'b0, mv2 = 1'b0;

  mode_detect_if st();

  mode_detect #(.STABLE_FRAMES(3), .H_TOL(2)) dut (
    .PCLK(PCLK), .reset_n(reset_n), .HSYNC_in(HSYNC_in), .VSYNC_in(VSYNC_in),
    .htotal(st.htotal), .hsync_w(st.hsync_w), .vtotal(st.vtotal), .vsync_w(st.vsync_w),
    .mode_valid(st.mode_valid), .mode_changed(st.mode_changed), .sync_lost(st.sync_lost)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int hper; int hlow; int lines; int vlow; int frames;
    int ht; int hw; int vt; int vw; int mv; int sl;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Video generator: H and V falling edges are aligned at the start of line 0.
  task automatic run_frames(input int hper, input int hlow, input int lines, input int vlow, input int frames);
    for (int f = 0; f < frames; f++)
      for (int l = 0; l < lines; l++)
        for (int c = 0; c < hper; c++) begin
          HSYNC_in = (c < hlow) ? 1'b0 : 1'b1;
          VSYNC_in = (l < vlow) ? 1'b0 : 1'b1;
          @(negedge PCLK);
        end
  endtask

  task automatic chk_status(input string tag, input int ht, input int hw, input int vt, input int vw,
                            input int mv, input int sl);
    chk({tag, ".htotal"}, int'(st.htotal), ht);
    chk({tag, ".hsync_w"}, int'(st.hsync_w), hw);
    chk({tag, ".vtotal"}, int'(st.vtotal), vt);
    chk({tag, ".vsync_w"}, int'(st.vsync_w), vw);
    chk({tag, ".mode_valid"}, int'(st.mode_valid), mv);
    chk({tag, ".sync_lost"}, int'(st.sync_lost), sl);
    $display("%s: htotal=%0d hsync_w=%0d vtotal=%0d vsync_w=%0d mode_valid=%0d sync_lost=%0d",
             tag, st.htotal, st.hsync_w, st.vtotal, st.vsync_w, st.mode_valid, st.sync_lost);
  endtask

  task automatic chk_reset(input string tag);
    chk_status(tag, 0, 0, 0, 0, 0, 1);
    chk({tag, ".mode_changed"}, int'(st.mode_changed), 0);
  endtask

  // mode_changed must be high exactly in the cycle after each mode_valid change.
  always @(negedge PCLK) begin
    if (!reset_n) begin
      mv1 = 1'b0;
      mv2 = 1'b0;
    end else begin
      if (st.mode_changed || (mv1 != mv2)) begin
        checks++;
        if (st.mode_changed != (mv1 != mv2)) begin
          errors++;
          $display("FAIL mode_changed_timing: got %0d expected %0d", st.mode_changed, (mv1 != mv2));
        end
      end
      if (st.mode_changed) mc_pulses++;
      mv2 = mv1;
      mv1 = st.mode_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{40, 4, 20, 3, 2, 40, 4, 20, 3, 0, 0};
    vecs[1]  = '{40, 4, 20, 3, 3, 40, 4, 20, 3, 1, 0};
    vecs[2]  = '{40, 4, 21, 3, 1, 40, 4, 20, 3, 1, 0};
    vecs[3]  = '{40, 4, 21, 3, 3, 40, 4, 21, 3, 0, 0};
    vecs[4]  = '{40, 4, 21, 3, 1, 40, 4, 21, 3, 1, 0};
    vecs[5]  = '{42, 4, 21, 3, 1, 42, 4, 21, 3, 1, 0};
    vecs[6]  = '{40, 4, 21, 3, 1, 40, 4, 21, 3, 1, 0};
    vecs[7]  = '{42, 4, 21, 3, 1, 42, 4, 21, 3, 1, 0};
    vecs[8]  = '{40, 4, 21, 3, 1, 40, 4, 21, 3, 1, 0};
    vecs[9]  = '{43, 4, 21, 3, 1, 43, 4, 21, 3, 1, 0};
    vecs[10] = '{40, 4, 21, 3, 1, 40, 4, 21, 3, 0, 0};

    reset_n  = 1'b0;
    HSYNC_in = 1'b1;
    VSYNC_in = 1'b1;
    #12;
    chk_reset("por");
    @(negedge PCLK);
    reset_n = 1'b1;
    repeat (4) @(negedge PCLK);

    for (int i = 0; i < 11; i++) begin
      run_frames(vecs[i].hper, vecs[i].hlow, vecs[i].lines, vecs[i].vlow, vecs[i].frames);
      chk_status($sformatf("vec%0d", i), vecs[i].ht, vecs[i].hw, vecs[i].vt, vecs[i].vw,
                 vecs[i].mv, vecs[i].sl);
    end
    chk("pulses_after_table", mc_pulses, 4);

    // Reset in the middle of a frame, then relock from scratch.
    run_frames(40, 4, 10, 3, 1);
    #2 reset_n = 1'b0;
    #1 chk_reset("midframe_reset");
    HSYNC_in = 1'b1;
    VSYNC_in = 1'b1;
    repeat (3) @(negedge PCLK);
    reset_n = 1'b1;
    repeat (4) @(negedge PCLK);
    run_frames(40, 4, 20, 3, 5);
    chk_status("relock", 40, 4, 20, 3, 1, 0);
    chk("pulses_after_relock", mc_pulses, 5);

    // Long vsync saturates the width; the 25-line frame then breaks lock.
    run_frames(40, 4, 25, 20, 2);
    chk_status("vsync_sat", 40, 4, 25, 15, 0, 0);

    run_frames(1024, 72, 6, 3, 2);
    chk_status("h1024", 1024, 72, 6, 3, 0, 0);

    // HSYNC stuck high: the H counter saturates roughly 3071 cycles into the hold.
    HSYNC_in = 1'b1;
    VSYNC_in = 1'b1;
    repeat (3000) @(negedge PCLK);
    chk("timeout_early.sync_lost", int'(st.sync_lost), 0);
    repeat (150) @(negedge PCLK);
    chk("timeout_hit.sync_lost", int'(st.sync_lost), 1);
    repeat (1850) @(negedge PCLK);
    chk_status("timeout_hold", 1024, 72, 6, 3, 0, 1);
    chk("pulses_final", mc_pulses, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
